// File: rtl/wb_retire_stage.sv
// Write-back/retire stage: one-entry pipeline register, exception cause resolution, flush sequencing.
// Optional WB_SOFT_INT_EN adds a soft_int input folded into exception source 0.
//   state  | meaning
//   RUN    | normal flow; retire or detect a trapping head
//   HOLD   | trapping head waiting for the I-cache to go idle
//   FLUSH  | one-cycle excp/ertn flush pulse, head dropped
module wb_retire_stage #(
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 128,
    parameter int EXCP_N    = 16,
    parameter logic [EXCP_N*6-1:0] ECODE_TABLE = {
        6'h01, 6'h02, 6'h07, 6'h04, 6'h3F, 6'h08, 6'h09, 6'h0E,
        6'h0D, 6'h0C, 6'h0B, 6'h07, 6'h03, 6'h3F, 6'h08, 6'h00},
    parameter logic [EXCP_N*9-1:0] ESUB_TABLE = {{5{9'd0}}, 9'd1, {10{9'd0}}},
    parameter logic [EXCP_N*2-1:0] BADV_SEL = {{7{2'd1}}, {4{2'd0}}, {4{2'd2}}, 2'd0},
    parameter logic [EXCP_N-1:0]   TLB_MASK    = 16'hF81C,
    parameter logic [EXCP_N-1:0]   REFILL_MASK = 16'h0804
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 icache_busy,
`ifdef WB_SOFT_INT_EN
    input  logic                 soft_int,
`endif
    input  logic                 left_valid,
    output logic                 left_ready,
    input  logic [DATA_W-1:0]    in_pc,
    input  logic [DATA_W-1:0]    in_mem_addr,
    input  logic                 in_wreg_en,
    input  logic [4:0]           in_wreg_idx,
    input  logic [DATA_W-1:0]    in_wdata,
    input  logic [EXCP_N-1:0]    in_excp,
    input  logic                 in_ertn,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 right_valid,
    input  logic                 right_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic [DATA_W+5:0]    wb_bypass,
    output logic                 excp_flush,
    output logic                 ertn_flush,
    output logic [DATA_W-1:0]    excp_era,
    output logic [5:0]           ecode,
    output logic [8:0]           esubcode,
    output logic [DATA_W-1:0]    badv,
    output logic                 badv_valid,
    output logic                 excp_tlb,
    output logic                 excp_tlbrefill,
    output logic                 stall
);

    typedef enum logic [1:0] {S_RUN, S_HOLD, S_FLUSH} state_t;

    state_t                state_q, state_d;
    logic                  valid_q;
    logic [DATA_W-1:0]     pc_q, mem_addr_q, wdata_q;
    logic                  wreg_en_q, ertn_q;
    logic [4:0]            wreg_idx_q;
    logic [EXCP_N-1:0]     excp_q, excp_eff;
    logic [PAYLOAD_W-1:0]  payload_q;

    logic                  trapping, has_excp, accept, retire;
    logic [5:0]            ecode_sel;
    logic [8:0]            esub_sel;
    logic [1:0]            bsel;
    logic                  tlb_sel, refill_sel;

    always_comb begin
        excp_eff = excp_q;
`ifdef WB_SOFT_INT_EN
        excp_eff[0] = excp_q[0] | soft_int;
`endif
    end

    assign has_excp = |excp_eff;
    assign trapping = valid_q & (has_excp | ertn_q);

    // Walk from the lowest-priority source down so the lowest set bit wins.
    always_comb begin
        ecode_sel  = '0;
        esub_sel   = '0;
        bsel       = '0;
        tlb_sel    = 1'b0;
        refill_sel = 1'b0;
        for (int i = EXCP_N - 1; i >= 0; i--) begin
            if (excp_eff[i]) begin
                ecode_sel  = ECODE_TABLE[i*6 +: 6];
                esub_sel   = ESUB_TABLE[i*9 +: 9];
                bsel       = BADV_SEL[i*2 +: 2];
                tlb_sel    = TLB_MASK[i];
                refill_sel = REFILL_MASK[i];
            end
        end
`ifdef WB_SOFT_INT_EN
        if (soft_int) bsel = '0;
`endif
    end

    assign ecode          = trapping ? ecode_sel : '0;
    assign esubcode       = trapping ? esub_sel : '0;
    assign badv_valid     = trapping & (bsel != 2'd0);
    assign badv           = !badv_valid ? '0 : (bsel == 2'd1) ? mem_addr_q : pc_q;
    assign excp_tlb       = trapping & tlb_sel;
    assign excp_tlbrefill = trapping & refill_sel;

    always_comb begin
        state_d     = state_q;
        left_ready  = 1'b0;
        right_valid = 1'b0;
        stall       = 1'b0;
        excp_flush  = 1'b0;
        ertn_flush  = 1'b0;
        case (state_q)
            S_RUN: begin
                if (trapping) begin
                    stall   = icache_busy;
                    state_d = icache_busy ? S_HOLD : S_FLUSH;
                end else begin
                    right_valid = valid_q;
                    left_ready  = !valid_q | right_ready;
                end
            end
            S_HOLD: begin
                stall = 1'b1;
                if (!icache_busy) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                excp_flush = valid_q & has_excp;
                ertn_flush = valid_q & !has_excp & ertn_q;
                state_d    = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    assign accept      = left_valid & left_ready;
    assign retire      = right_valid & right_ready;
    assign excp_era    = (excp_flush | ertn_flush) ? pc_q : '0;
    assign rf_we       = right_valid & wreg_en_q;
    assign rf_waddr    = wreg_idx_q;
    assign rf_wdata    = wdata_q;
    assign wb_bypass   = {rf_wdata, rf_waddr, rf_we};
    assign out_payload = payload_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RUN;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            wreg_en_q  <= 1'b0;
            wreg_idx_q <= '0;
            excp_q     <= '0;
            ertn_q     <= 1'b0;
            payload_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                valid_q    <= 1'b1;
                pc_q       <= in_pc;
                mem_addr_q <= in_mem_addr;
                wdata_q    <= in_wdata;
                wreg_en_q  <= in_wreg_en;
                wreg_idx_q <= in_wreg_idx;
                excp_q     <= in_excp;
                ertn_q     <= in_ertn;
                payload_q  <= in_payload;
            end else if (state_q == S_FLUSH || retire) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_retire_stage.sv
// Directed bench for wb_retire_stage: vector table for single instructions plus
// hand-written busy-hold, backpressure and reset-in-hold sequences.
module tb_wb_retire_stage;

    logic         clk = 1'b0;
    logic         reset, icache_busy, left_valid, left_ready;
    logic [31:0]  in_pc, in_mem_addr, in_wdata;
    logic         in_wreg_en, in_ertn;
    logic [4:0]   in_wreg_idx;
    logic [15:0]  in_excp;
    logic [127:0] in_payload, out_payload;
    logic         right_valid, right_ready;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata, excp_era, badv;
    logic [37:0]  wb_bypass;
    logic         excp_flush, ertn_flush, badv_valid, excp_tlb, excp_tlbrefill, stall;
    logic [5:0]   ecode;
    logic [8:0]   esubcode;
`ifdef WB_SOFT_INT_EN
    logic         soft_int = 1'b0;
`endif

    always #5 clk = ~clk;

    wb_retire_stage dut (
        .clk(clk), .reset(reset), .icache_busy(icache_busy),
`ifdef WB_SOFT_INT_EN
        .soft_int(soft_int),
`endif
        .left_valid(left_valid), .left_ready(left_ready),
        .in_pc(in_pc), .in_mem_addr(in_mem_addr), .in_wreg_en(in_wreg_en),
        .in_wreg_idx(in_wreg_idx), .in_wdata(in_wdata), .in_excp(in_excp),
        .in_ertn(in_ertn), .in_payload(in_payload),
        .right_valid(right_valid), .right_ready(right_ready), .out_payload(out_payload),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_bypass(wb_bypass),
        .excp_flush(excp_flush), .ertn_flush(ertn_flush), .excp_era(excp_era),
        .ecode(ecode), .esubcode(esubcode), .badv(badv), .badv_valid(badv_valid),
        .excp_tlb(excp_tlb), .excp_tlbrefill(excp_tlbrefill), .stall(stall)
    );

    typedef struct {
        logic [15:0] excp;
        logic        ertn;
        logic        wen;
        logic [4:0]  widx;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] maddr;
        logic [5:0]  e_ecode;
        logic [8:0]  e_esub;
        logic [31:0] e_badv;
        logic        e_bv;
        logic        e_tlb;
        logic        e_refill;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] excp, input logic ertn, input logic wen,
                         input logic [4:0] widx, input logic [31:0] wdata,
                         input logic [31:0] pc, input logic [31:0] maddr);
        left_valid  = 1'b1;
        in_excp     = excp;
        in_ertn     = ertn;
        in_wreg_en  = wen;
        in_wreg_idx = widx;
        in_wdata    = wdata;
        in_pc       = pc;
        in_mem_addr = maddr;
        in_payload  = {pc, maddr, wdata, ~pc};
    endtask

    vec_t vt[12];

    initial begin
        logic trap;
        vt[0]  = '{16'h0000, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 32'h1C000000, 32'h0,        6'h00, 9'd0, 32'h0,        1'b0, 1'b0, 1'b0};
        vt[1]  = '{16'h0220, 1'b0, 1'b1, 5'd3,  32'h12345678, 32'h1C000010, 32'h1C000020, 6'h0B, 9'd0, 32'h0,        1'b0, 1'b0, 1'b0};
        vt[2]  = '{16'h0200, 1'b0, 1'b0, 5'd0,  32'h0,        32'h1C000100, 32'h1C000003, 6'h09, 9'd0, 32'h1C000003, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{16'h0000, 1'b1, 1'b0, 5'd0,  32'h0,        32'h1C000200, 32'h0,        6'h00, 9'd0, 32'h0,        1'b0, 1'b0, 1'b0};
        vt[4]  = '{16'h0002, 1'b1, 1'b0, 5'd0,  32'h0,        32'h1C000300, 32'h0BAD0000, 6'h08, 9'd0, 32'h1C000300, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{16'h0400, 1'b0, 1'b1, 5'd9,  32'h5,        32'h1C000400, 32'h00001234, 6'h08, 9'd1, 32'h00001234, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{16'h8000, 1'b0, 1'b0, 5'd0,  32'h0,        32'h1C000500, 32'h0000A000, 6'h01, 9'd0, 32'h0000A000, 1'b1, 1'b1, 1'b0};
        vt[7]  = '{16'h0800, 1'b0, 1'b0, 5'd0,  32'h0,        32'h1C000600, 32'h0000B000, 6'h3F, 9'd0, 32'h0000B000, 1'b1, 1'b1, 1'b1};
        vt[8]  = '{16'h0001, 1'b0, 1'b1, 5'd1,  32'h1,        32'h1C000700, 32'h0000C000, 6'h00, 9'd0, 32'h0,        1'b0, 1'b0, 1'b0};
        vt[9]  = '{16'h0000, 1'b0, 1'b0, 5'd12, 32'hCAFEF00D, 32'h1C000800, 32'h0,        6'h00, 9'd0, 32'h0,        1'b0, 1'b0, 1'b0};
        vt[10] = '{16'h0008, 1'b0, 1'b0, 5'd0,  32'h0,        32'h1C000900, 32'h0000D000, 6'h03, 9'd0, 32'h1C000900, 1'b1, 1'b1, 1'b0};
        vt[11] = '{16'h1001, 1'b0, 1'b0, 5'd0,  32'h0,        32'h1C000A00, 32'h0000E000, 6'h00, 9'd0, 32'h0,        1'b0, 1'b0, 1'b0};

        reset = 1'b1; icache_busy = 1'b0; right_ready = 1'b1;
        drive(16'h0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        left_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst left_ready", left_ready, 1);
        chk("rst right_valid", right_valid, 0);
        chk("rst rf_we", rf_we, 0);
        chk("rst bypass", wb_bypass, 0);
        chk("rst payload", out_payload, 0);
        chk("rst flush", {excp_flush, ertn_flush}, 0);
        chk("rst era", excp_era, 0);
        chk("rst cause", {ecode, esubcode, badv, badv_valid, excp_tlb, excp_tlbrefill}, 0);
        chk("rst stall", stall, 0);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vt[i].excp, vt[i].ertn, vt[i].wen, vt[i].widx, vt[i].wdata, vt[i].pc, vt[i].maddr);
            #1 chk($sformatf("v%0d accept", i), left_ready, 1);
            trap = (|vt[i].excp) | vt[i].ertn;
            @(negedge clk);
            left_valid = 1'b0;
            #1;
            chk($sformatf("v%0d rv", i), right_valid, !trap);
            chk($sformatf("v%0d we", i), rf_we, !trap & vt[i].wen);
            chk($sformatf("v%0d bypass", i), wb_bypass, {vt[i].wdata, vt[i].widx, !trap & vt[i].wen});
            chk($sformatf("v%0d payload", i), out_payload, {vt[i].pc, vt[i].maddr, vt[i].wdata, ~vt[i].pc});
            chk($sformatf("v%0d cause", i), {ecode, esubcode, badv, badv_valid, excp_tlb, excp_tlbrefill},
                {vt[i].e_ecode, vt[i].e_esub, vt[i].e_badv, vt[i].e_bv, vt[i].e_tlb, vt[i].e_refill});
            chk($sformatf("v%0d c1 flush", i), {excp_flush, ertn_flush, stall}, 0);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d c2 rv", i), {right_valid, rf_we}, 0);
            chk($sformatf("v%0d c2 flush", i), {excp_flush, ertn_flush},
                {trap & (|vt[i].excp), trap & !(|vt[i].excp)});
            chk($sformatf("v%0d c2 era", i), excp_era, trap ? vt[i].pc : 32'h0);
            if (trap)
                chk($sformatf("v%0d c2 ecode", i), ecode, vt[i].e_ecode);
        end

        // I-cache busy while a TLB refill exception is at the head
        @(negedge clk);
        icache_busy = 1'b1;
        drive(16'h0004, 1'b0, 1'b1, 5'd4, 32'h44, 32'h1C001000, 32'h0000F000);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            left_valid = 1'b0;
            #1;
            chk($sformatf("busy c%0d stall", c), stall, 1);
            chk($sformatf("busy c%0d left_ready", c), left_ready, 0);
            chk($sformatf("busy c%0d flush", c), excp_flush, 0);
            chk($sformatf("busy c%0d rv/we", c), {right_valid, rf_we}, 0);
        end
        @(negedge clk);
        icache_busy = 1'b0;
        #1;
        chk("busy drop stall", stall, 1);
        chk("busy drop flush", excp_flush, 0);
        @(negedge clk);
        #1;
        chk("busy flush", excp_flush, 1);
        chk("busy flush cause", {ecode, excp_tlb, excp_tlbrefill, badv, badv_valid},
            {6'h3F, 1'b1, 1'b1, 32'h1C001000, 1'b1});
        chk("busy flush era", excp_era, 32'h1C001000);
        chk("busy flush left_ready", left_ready, 0);
        @(negedge clk);
        #1;
        chk("busy after flush", {excp_flush, stall, left_ready}, 3'b001);

        // Backpressure: head stays, next instruction waits, then retire + accept together
        right_ready = 1'b0;
        drive(16'h0, 1'b0, 1'b1, 5'd7, 32'h11111111, 32'h1C002000, 32'h0);
        @(negedge clk);
        drive(16'h0, 1'b0, 1'b1, 5'd8, 32'h22222222, 32'h1C002004, 32'h0);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("bp c%0d left_ready", c), left_ready, 0);
            chk($sformatf("bp c%0d head", c), {right_valid, rf_we, rf_waddr, rf_wdata}, {1'b1, 1'b1, 5'd7, 32'h11111111});
            @(negedge clk);
        end
        right_ready = 1'b1;
        #1 chk("bp release left_ready", left_ready, 1);
        @(negedge clk);
        left_valid = 1'b0;
        #1 chk("bp next head", {right_valid, rf_we, rf_waddr, rf_wdata}, {1'b1, 1'b1, 5'd8, 32'h22222222});
        @(negedge clk);
        #1 chk("bp drained", right_valid, 0);

        // Reset while holding: no flush may ever appear
        icache_busy = 1'b1;
        drive(16'h0004, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1C003000, 32'h0);
        @(negedge clk);
        left_valid = 1'b0;
        @(negedge clk);
        #1 chk("rh hold stall", stall, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        icache_busy = 1'b0;
        #1;
        chk("rh stall", stall, 0);
        chk("rh rv", right_valid, 0);
        chk("rh left_ready", left_ready, 1);
        chk("rh flush", excp_flush, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 chk($sformatf("rh c%0d no flush", c), {excp_flush, ertn_flush, stall}, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_retire_stage.md
Name: wb_retire_stage

Overview:
Registered, parametrised write-back/retire stage. It sits between MEM and the commit/CSR side of the pipeline.
- Holds one instruction in a valid/ready pipeline register.
- Resolves a generic N-source exception vector into ecode/esubcode/badv using table parameters.
- Sequences excp/ertn flushes against a busy I-cache with an explicit FSM.
- Drives the register-file write port and the WB bypass.

Parameters:
DATA_W, 32, width of PC, write data, mem address and badv
PAYLOAD_W, 128, opaque side-band bits carried through unchanged (tlb ops, timer, inst word)
EXCP_N, 16, number of exception sources; bit 0 has highest priority
ECODE_TABLE, LoongArch default {INT 0x00, ADEF 0x08, TLBR 0x3F, PIF 0x03, PPI 0x07, SYS 0x0B, BRK 0x0C, INE 0x0D, IPE 0x0E, ALE 0x09, ADEM 0x08, TLBR 0x3F, PME 0x04, PPI 0x07, PIS 0x02, PIL 0x01}, packed EXCP_N*6 ecode per source
ESUB_TABLE, 0 except ADEF=0, ADEM=1, packed EXCP_N*9 esubcode per source
BADV_SEL, 2 for idx 1-4, 1 for idx 9-15, 0 otherwise, packed EXCP_N*2; 0 = no badv, 1 = mem_addr, 2 = PC
TLB_MASK, idx 2,3,4,11-15 set, EXCP_N bits; source counts as a TLB exception
REFILL_MASK, idx 2,11 set, EXCP_N bits; source counts as a TLB refill

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
icache_busy  in  1  I-cache refill in progress; a flush must not issue while high
left_valid  in  1  MEM has an instruction
left_ready  out  1  stage can accept
in_pc  in  DATA_W  instruction PC
in_mem_addr  in  DATA_W  data address
in_wreg_en  in  1  register write request
in_wreg_idx  in  5  destination register
in_wdata  in  DATA_W  write data
in_excp  in  EXCP_N  exception vector
in_ertn  in  1  ertn instruction
in_payload  in  PAYLOAD_W  side-band bits
right_valid  out  1  retiring instruction valid
right_ready  in  1  commit side can take it
out_payload  out  PAYLOAD_W  registered side-band bits
rf_we / rf_waddr / rf_wdata  out  1/5/DATA_W  register-file write port
wb_bypass  out  DATA_W+6  {rf_wdata, rf_waddr, rf_we}
excp_flush / ertn_flush  out  1/1  one-cycle flush pulses
excp_era  out  DATA_W  PC of the flushing instruction
ecode / esubcode  out  6/9  resolved cause
badv / badv_valid  out  DATA_W/1  bad address
excp_tlb / excp_tlbrefill  out  1/1  from TLB_MASK / REFILL_MASK
stall  out  1  flush waiting on icache_busy

Behaviour:
- Reset: valid_q=0, FSM=RUN, all registered fields 0. Every output 0 except left_ready=1.
- Latency: 1 cycle. Data accepted on (left_valid & left_ready) appears on right_valid/out_* the next cycle.
- Head is "trapping" when valid_q & (|excp_q | ertn_q).
- Cause resolution is combinational from the registered head:
  - idx = lowest set bit of excp_q; ecode and esubcode come from the tables at idx.
  - badv follows BADV_SEL[idx]; badv_valid = (BADV_SEL != 0) & trapping.
  - All cause outputs are 0 when the head is not trapping.
- Exception beats ertn when both are set; ertn_flush stays 0.
- FSM:
  - RUN:
    - Non-trapping head: right_valid=valid_q. Retire on right_ready. left_ready = !valid_q | right_ready.
    - Trapping head with icache_busy=1: go to HOLD, stall=1.
    - Trapping head with icache_busy=0: go to FLUSH.
  - HOLD: stall=1, left_ready=0, right_valid=0. Go to FLUSH on the first cycle icache_busy=0.
  - FLUSH (exactly 1 cycle):
    - excp_flush or ertn_flush=1, excp_era=pc_q.
    - valid_q cleared; left_ready=0, so nothing is accepted that cycle.
    - Next state RUN.
- A trapping head never asserts right_valid, rf_we or the bypass enable; it does not retire.
- rf_we = valid_q & wreg_en_q & !trapping & (FSM==RUN). The bypass carries the same value.
- A register is loaded only on accept. With no accept, valid_q holds; if retired with no new input, it goes to 0.
- Reset asserted in HOLD or FLUSH returns to RUN with valid_q=0 next cycle; no flush pulse is emitted.
- EXCP_N=1 is legal: idx is always 0.

Optional Feature:
Macro WB_SOFT_INT_EN.
- Defined:
  - Adds input soft_int (1 bit), ORed into excp bit 0 when evaluating the head.
  - The head becomes trapping when valid_q & soft_int, even with an empty excp vector.
  - Cause is ecode=ECODE_TABLE[0] with badv_valid=0.
- Undefined: port absent; behaviour as above.

Test Plan:
- Plain retire: in_wreg_en=1, idx=5, wdata=0xDEADBEEF, right_ready=1 -> next cycle right_valid=1, rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, bypass enable=1.
- Priority: in_excp=0x0220 (SYS idx5 + ALE idx9), icache_busy=0 -> FLUSH cycle with excp_flush=1, ecode=0x0B, badv_valid=0, rf_we=0, right_valid=0.
- Badv: in_excp=0x0200, in_mem_addr=0x1C000003, pc=0x1C000100 -> ecode=0x09, badv=0x1C000003, badv_valid=1, excp_era=0x1C000100.
- Busy hold: in_excp=0x0004, icache_busy=1 for 3 cycles -> stall=1 and left_ready=0 for 3 cycles; excp_flush=1 exactly once, on the cycle after busy drops; ecode=0x3F, excp_tlb=1, excp_tlbrefill=1.
- Backpressure: right_ready=0 with valid head, left_valid=1 -> left_ready=0, head stable 4 cycles; right_ready=1 -> retire and accept the next instruction the same cycle.
- Reset in HOLD: reset=1 for 1 cycle -> next cycle valid_q=0, stall=0, no flush pulse ever emitted.
